// File: rtl/branch_res_queue.sv
// branch_res_queue: in-order BTB prediction queue that resolves the oldest branch into BTB updates and mispredict redirects (optional head-PC check: RES_PC_CHECK_EN)
package mmm_pkg;
    parameter int XLEN = 32;
    parameter int OFFSET = 2;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;
endpackage

module branch_res_queue
    import mmm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [XLEN-1:0]          pred_pc_i,
    input  logic                     pred_taken_i,
    input  logic [XLEN-OFFSET-1:0]   pred_target_i,
    input  logic                     exe_valid_i,
    input  logic [XLEN-1:0]          exe_pc_i,
    input  logic                     exe_taken_i,
    input  logic [XLEN-1:0]          exe_target_i,
    output logic                     res_valid_o,
    output logic                     del_entry_o,
    output resolution_t              res_o,
    output logic                     mispredict_o,
    output logic [XLEN-1:0]          redirect_pc_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0]        r_pc [DEPTH];
    logic [XLEN-OFFSET-1:0] r_tgt [DEPTH];
    logic [DEPTH-1:0]       r_taken;
    logic [AW-1:0]          r_head, r_tail;
    logic [AW:0]            r_count;

    logic                   w_empty, w_h_taken, w_pc_err, w_tgt_mis;
    logic                   w_mis, w_upd, w_err, w_push, w_pop, w_clear;
    logic [XLEN-1:0]        w_h_pc;

    assign w_empty      = r_count == '0;
    assign pred_ready_o = r_count != FULL;
    assign count_o      = r_count;

    // An empty queue resolves as if the branch had been predicted not-taken.
    assign w_h_taken = !w_empty && r_taken[r_head];
    assign w_h_pc    = w_empty ? exe_pc_i : r_pc[r_head];
`ifdef RES_PC_CHECK_EN
    assign w_pc_err  = !w_empty && (exe_pc_i != r_pc[r_head]);
`else
    assign w_pc_err  = 1'b0;
`endif
    assign w_tgt_mis = exe_taken_i && w_h_taken && (exe_target_i[XLEN-1:OFFSET] != r_tgt[r_head]);
    assign w_mis     = exe_valid_i && ((exe_taken_i != w_h_taken) || w_tgt_mis || w_pc_err);
    assign w_upd     = exe_valid_i && !w_pc_err && (exe_taken_i ? (!w_h_taken || w_tgt_mis) : w_h_taken);
    assign w_err     = exe_valid_i && (w_empty || w_pc_err);
    // A mispredict squashes every younger entry, so the whole queue (and any push) is discarded.
    assign w_clear   = flush_i || w_mis;
    assign w_push    = pred_valid_i && pred_ready_o && !w_clear;
    assign w_pop     = exe_valid_i && !w_empty && !w_clear;

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Prediction storage, written at the tail on push.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc[r_tail]    <= pred_pc_i;
            r_tgt[r_tail]   <= pred_target_i;
            r_taken[r_tail] <= pred_taken_i;
        end
    end

    // Registered resolution results; pulses last one cycle and flush suppresses them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o   <= 1'b0;
            del_entry_o   <= 1'b0;
            mispredict_o  <= 1'b0;
            err_o         <= 1'b0;
            res_o         <= '0;
            redirect_pc_o <= '0;
        end else begin
            res_valid_o  <= !flush_i && w_upd;
            del_entry_o  <= !flush_i && w_upd && !exe_taken_i;
            mispredict_o <= !flush_i && w_mis;
            err_o        <= !flush_i && w_err;
            if (exe_valid_i && !flush_i) begin
                res_o.pc      <= w_h_pc;
                res_o.target  <= exe_target_i;
                redirect_pc_o <= exe_taken_i ? exe_target_i : exe_pc_i + XLEN'(4);
            end
        end
    end
endmodule

// File: tb/tb_branch_res_queue.sv
// tb_branch_res_queue: directed vector table plus randomized run against a queue-based reference model
module tb_branch_res_queue;
    import mmm_pkg::*;

    logic clk = 0, rst = 1, flush = 0;
    logic pv = 0, pt = 0, ev = 0, et = 0;
    logic [31:0] ppc = 0, epc = 0, etg = 0;
    logic [29:0] ptg = 0;
    logic rdy, rv, del, mis, err;
    resolution_t res;
    logic [31:0] rpc;
    logic [2:0] cnt;
    int tests = 0, fails = 0;

    branch_res_queue #(.DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .pred_valid_i(pv), .pred_ready_o(rdy), .pred_pc_i(ppc), .pred_taken_i(pt), .pred_target_i(ptg),
        .exe_valid_i(ev), .exe_pc_i(epc), .exe_taken_i(et), .exe_target_i(etg),
        .res_valid_o(rv), .del_entry_o(del), .res_o(res), .mispredict_o(mis),
        .redirect_pc_o(rpc), .err_o(err), .count_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pv; logic [31:0] ppc; logic pt; logic [29:0] ptg;
        logic ev; logic [31:0] epc; logic et; logic [31:0] etg; logic fl;
        logic [2:0] cnt; logic rdy; logic mis; logic rv; logic del; logic err;
        logic [31:0] rpc; logic [31:0] rp;
    } vec_t;
    vec_t tv[$];

    typedef struct { logic [31:0] pc; logic t; logic [29:0] tg; } ent_t;
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input vec_t v);
        tv.push_back(v);
    endtask

    task automatic drive(input logic a_pv, input logic [31:0] a_ppc, input logic a_pt, input logic [29:0] a_ptg,
                         input logic a_ev, input logic [31:0] a_epc, input logic a_et, input logic [31:0] a_etg,
                         input logic a_fl);
        pv = a_pv; ppc = a_ppc; pt = a_pt; ptg = a_ptg;
        ev = a_ev; epc = a_epc; et = a_et; etg = a_etg; flush = a_fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // directed sequence: each row is one cycle, expectations observed after that edge
        add('{1,'h100,0,0,        0,0,0,0,0,               1,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,'h100,1,'h200,0,       0,1,1,1,0,0,'h200,'h100});
        add('{1,'h100,1,'h80,     0,0,0,0,0,               1,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,'h100,0,0,0,           0,1,1,1,1,0,'h104,'h100});
        add('{1,'h100,1,'h80,     0,0,0,0,0,               1,1,0,0,0,0,0,0});
        add('{1,'h110,0,0,        0,0,0,0,0,               2,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,'h100,1,'h200,0,       1,1,0,0,0,0,'h200,0});
        add('{0,0,0,0,            1,'h110,0,0,0,           0,1,0,0,0,0,'h114,0});
        add('{1,'h10,0,0,         0,0,0,0,0,               1,1,0,0,0,0,0,0});
        add('{1,'h20,0,0,         0,0,0,0,0,               2,1,0,0,0,0,0,0});
        add('{1,'h30,0,0,         0,0,0,0,0,               3,1,0,0,0,0,0,0});
        add('{1,'h40,0,0,         0,0,0,0,0,               4,0,0,0,0,0,0,0});
        add('{1,'h50,0,0,         1,'h10,0,0,0,            3,1,0,0,0,0,'h14,0});
        add('{1,'h60,0,0,         1,'h20,1,'h300,0,        0,1,1,1,0,0,'h300,'h20});
        add('{1,'h70,0,0,         0,0,0,0,0,               1,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,'h70,1,'h400,1,        0,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,0,1,'h40,0,            0,1,1,1,0,1,'h40,0});
        add('{0,0,0,0,            1,'hFFFFFFFC,0,0,0,      0,1,0,0,0,1,0,0});
        add('{1,'hFFFFFFFC,1,'h3FFFFFFF, 0,0,0,0,0,        1,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,'hFFFFFFFC,0,0,0,      0,1,1,1,1,0,0,'hFFFFFFFC});
        add('{1,'h100,1,'h80,     0,0,0,0,0,               1,1,0,0,0,0,0,0});
        add('{0,0,0,0,            1,'h100,1,'h300,0,       0,1,1,1,0,0,'h300,'h100});
        add('{1,'h100,1,'h80,     0,0,0,0,0,               1,1,0,0,0,0,0,0});
`ifdef RES_PC_CHECK_EN
        add('{0,0,0,0,            1,'h104,1,'h200,0,       0,1,1,0,0,1,'h200,0});
`else
        add('{0,0,0,0,            1,'h104,1,'h200,0,       0,1,0,0,0,0,'h200,0});
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(cnt), 0);
        chk("reset_ready", 32'(rdy), 1);
        chk("reset_pulses", {28'd0, rv, del, mis, err}, 0);
        chk("reset_res", res.pc | res.target, 0);
        chk("reset_redirect", rpc, 0);
        rst = 0;

        foreach (tv[i]) begin
            drive(tv[i].pv, tv[i].ppc, tv[i].pt, tv[i].ptg, tv[i].ev, tv[i].epc, tv[i].et, tv[i].etg, tv[i].fl);
            chk($sformatf("row%0d_count", i), 32'(cnt), 32'(tv[i].cnt));
            chk($sformatf("row%0d_ready", i), 32'(rdy), 32'(tv[i].rdy));
            chk($sformatf("row%0d_mispredict", i), 32'(mis), 32'(tv[i].mis));
            chk($sformatf("row%0d_res_valid", i), 32'(rv), 32'(tv[i].rv));
            chk($sformatf("row%0d_del_entry", i), 32'(del), 32'(tv[i].del));
            chk($sformatf("row%0d_err", i), 32'(err), 32'(tv[i].err));
            if (tv[i].ev && !tv[i].fl) chk($sformatf("row%0d_redirect", i), rpc, tv[i].rpc);
            if (tv[i].rv) begin
                chk($sformatf("row%0d_res_pc", i), res.pc, tv[i].rp);
                chk($sformatf("row%0d_res_target", i), res.target, tv[i].etg);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized run against a queue model
        q.delete();
        for (int n = 0; n < 400; n++) begin
            logic a_pv, a_pt, a_ev, a_et, a_fl, ht, perr, tmis, x_mis, x_rv, x_err, ready;
            logic [31:0] a_ppc, a_epc, a_etg, hpc, x_rpc;
            logic [29:0] a_ptg, htg;
            a_pv  = 1'($urandom_range(0, 1));
            a_ppc = 32'($urandom_range(0, 255)) << 2;
            a_pt  = 1'($urandom_range(0, 1));
            a_ptg = 30'($urandom_range(0, 3));
            a_ev  = $urandom_range(0, 9) < 4;
            a_epc = (q.size() != 0 && $urandom_range(0, 7) != 0) ? q[0].pc : 32'($urandom_range(0, 255)) << 2;
            a_et  = 1'($urandom_range(0, 1));
            a_etg = 32'($urandom_range(0, 3)) << 2;
            a_fl  = $urandom_range(0, 19) == 0;
            ready = q.size() != 4;
            ht    = q.size() != 0 ? q[0].t : 1'b0;
            htg   = q.size() != 0 ? q[0].tg : 30'd0;
            hpc   = q.size() != 0 ? q[0].pc : a_epc;
`ifdef RES_PC_CHECK_EN
            perr  = q.size() != 0 && a_epc != q[0].pc;
`else
            perr  = 1'b0;
`endif
            tmis  = a_et && ht && (a_etg[31:2] != htg);
            x_mis = a_ev && !a_fl && (a_et != ht || tmis || perr);
            x_rv  = a_ev && !a_fl && !perr && (a_et != ht || tmis);
            x_err = a_ev && !a_fl && (q.size() == 0 || perr);
            x_rpc = a_et ? a_etg : a_epc + 32'd4;
            if (a_fl || x_mis) q.delete();
            else begin
                if (a_ev && q.size() != 0) void'(q.pop_front());
                if (a_pv && ready) q.push_back('{a_ppc, a_pt, a_ptg});
            end
            drive(a_pv, a_ppc, a_pt, a_ptg, a_ev, a_epc, a_et, a_etg, a_fl);
            chk("rnd_count", 32'(cnt), q.size());
            chk("rnd_ready", 32'(rdy), 32'(q.size() != 4));
            chk("rnd_mispredict", 32'(mis), 32'(x_mis));
            chk("rnd_res_valid", 32'(rv), 32'(x_rv));
            chk("rnd_del_entry", 32'(del), 32'(x_rv && !a_et));
            chk("rnd_err", 32'(err), 32'(x_err));
            if (a_ev && !a_fl) chk("rnd_redirect", rpc, x_rpc);
            if (x_rv) begin
                chk("rnd_res_pc", res.pc, hpc);
                chk("rnd_res_target", res.target, a_etg);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
